// File: rtl/main_ram_multi.sv
// Byte-addressed main memory built from NUM_BLKS single-port 16-bit blocks,
// with a read strobe/valid pipeline, optional output register and clear engine.

module main_ram_multi_sp256k (
    input  logic        clk,
    input  logic [13:0] ad,
    input  logic [15:0] di,
    input  logic [3:0]  maskwe,
    input  logic        we,
    input  logic        cs,
    input  logic        stdby,
    input  logic        sleep,
    input  logic        pwroff_n,
    output logic [15:0] dout
);
    logic [15:0] mem [0:16383];
    logic        active;

    assign active = cs & ~stdby & ~sleep & pwroff_n;

    // Each maskwe bit enables one nibble; reads register the addressed word.
    always_ff @(posedge clk) begin
        if (active && we) begin
            for (int n = 0; n < 4; n++) begin
                if (maskwe[n]) mem[ad][n*4 +: 4] <= di[n*4 +: 4];
            end
        end else if (active) begin
            dout <= mem[ad];
        end
    end
endmodule

module main_ram_multi #(
    parameter int         NUM_BLKS       = 2,
    parameter int         REG_OUT        = 0,
    parameter int         CLEAR_ON_RESET = 1,
    parameter logic [7:0] CLEAR_VALUE    = 8'h00,
    localparam int        SEL_W          = $clog2(NUM_BLKS),
    localparam int        BLK_W          = (SEL_W < 1) ? 1 : SEL_W,
    localparam int        ADDR_W         = 15 + SEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [7:0]        bus_wrdata,
    input  logic              bus_write,
    input  logic              bus_read,
    output logic [7:0]        bus_rddata,
    output logic              bus_rdvalid,
    input  logic              clr_start,
    output logic              busy
);
    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

    state_t      state, state_nxt;
    logic [13:0] clr_cnt, clr_cnt_nxt;
    logic [BLK_W-1:0] blk_sel;
    logic        wr_en, rd_en;
    logic        rd_v1, rd_lane_q;
    logic [BLK_W-1:0] rd_blk_q;
    logic [15:0] ram_do [NUM_BLKS];
    logic [15:0] do_sel;
    logic [7:0]  rd_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RESET_STATE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            S_IDLE: begin
                if (clr_start) begin
                    state_nxt   = S_CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            S_CLEAR: begin
                clr_cnt_nxt = clr_cnt + 14'd1;
                if (clr_cnt == 14'h3FFF) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy  = (state == S_CLEAR);
    assign wr_en = ~busy & bus_write;
    assign rd_en = ~busy & bus_read & ~bus_write;

    generate
        if (NUM_BLKS > 1) begin : g_sel
            assign blk_sel = bus_addr[ADDR_W-1:15];
        end else begin : g_nosel
            assign blk_sel = '0;
        end
    endgenerate

    // During a clear every block is written in parallel with the counter address.
    for (genvar i = 0; i < NUM_BLKS; i++) begin : g_blk
        logic hit;
        assign hit = (blk_sel == BLK_W'(i));
        main_ram_multi_sp256k u_ram (
            .clk      (clk),
            .ad       (busy ? clr_cnt : bus_addr[14:1]),
            .di       (busy ? {CLEAR_VALUE, CLEAR_VALUE} : {bus_wrdata, bus_wrdata}),
            .maskwe   (busy ? 4'b1111 : (bus_addr[0] ? 4'b1100 : 4'b0011)),
            .we       (busy | (wr_en & hit)),
            .cs       (busy | ((wr_en | rd_en) & hit)),
            .stdby    (1'b0),
            .sleep    (1'b0),
            .pwroff_n (1'b1),
            .dout     (ram_do[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1     <= 1'b0;
            rd_blk_q  <= '0;
            rd_lane_q <= 1'b0;
        end else begin
            rd_v1 <= rd_en;
            if (rd_en) begin
                rd_blk_q  <= blk_sel;
                rd_lane_q <= bus_addr[0];
            end
        end
    end

    assign do_sel  = ram_do[rd_blk_q];
    assign rd_byte = rd_lane_q ? do_sel[15:8] : do_sel[7:0];

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic       rd_v2;
            logic [7:0] rd_byte_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_v2     <= 1'b0;
                    rd_byte_q <= '0;
                end else begin
                    rd_v2 <= rd_v1;
                    if (rd_v1) rd_byte_q <= rd_byte;
                end
            end
            assign bus_rdvalid = rd_v2;
            assign bus_rddata  = rd_byte_q;
        end else begin : g_comb_out
            assign bus_rdvalid = rd_v1;
            assign bus_rddata  = rd_byte;
        end
    endgenerate
endmodule

// File: tb/tb_main_ram_multi.sv
// Directed bench: two instances (REG_OUT=0 and REG_OUT=1) share all inputs
// so every read checks both latencies at once.

module tb_main_ram_multi;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [16:0] bus_addr = '0;
    logic [7:0]  bus_wrdata = '0;
    logic        bus_write = 1'b0;
    logic        bus_read = 1'b0;
    logic        clr_start = 1'b0;
    logic [7:0]  rddata0, rddata1;
    logic        rdvalid0, rdvalid1;
    logic        busy0, busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    main_ram_multi #(.NUM_BLKS(4), .REG_OUT(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'hA5)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_wrdata(bus_wrdata),
        .bus_write(bus_write), .bus_read(bus_read), .bus_rddata(rddata0),
        .bus_rdvalid(rdvalid0), .clr_start(clr_start), .busy(busy0)
    );

    main_ram_multi #(.NUM_BLKS(4), .REG_OUT(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(8'hA5)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_wrdata(bus_wrdata),
        .bus_write(bus_write), .bus_read(bus_read), .bus_rddata(rddata1),
        .bus_rdvalid(rdvalid1), .clr_start(clr_start), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int start);
        int n;
        n = start;
        while (busy0 && n < 20000) begin
            step();
            n++;
        end
        chk(tag, n, 16384);
        chk({tag, "_both"}, {31'd0, busy1}, 0);
    endtask

    task automatic do_write(input logic [16:0] a, input logic [7:0] d);
        bus_addr   = a;
        bus_wrdata = d;
        bus_write  = 1'b1;
        step();
        bus_write  = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [16:0] a, input logic [7:0] exp);
        bus_addr = a;
        bus_read = 1'b1;
        step();
        bus_read = 1'b0;
        chk({tag, "_v0"}, {31'd0, rdvalid0}, 1);
        chk({tag, "_d0"}, {24'd0, rddata0}, {24'd0, exp});
        chk({tag, "_v1_early"}, {31'd0, rdvalid1}, 0);
        step();
        chk({tag, "_v0_after"}, {31'd0, rdvalid0}, 0);
        chk({tag, "_v1"}, {31'd0, rdvalid1}, 1);
        chk({tag, "_d1"}, {24'd0, rddata1}, {24'd0, exp});
    endtask

    initial begin
        logic [16:0] b2b_addr [4];
        logic [7:0]  b2b_exp  [4];
        b2b_addr = '{17'h08000, 17'h08001, 17'h00000, 17'h00001};
        b2b_exp  = '{8'h11, 8'h22, 8'h33, 8'hA5};

        // Reset values and the automatic clear after reset.
        step();
        step();
        chk("rst_valid0", {31'd0, rdvalid0}, 0);
        chk("rst_valid1", {31'd0, rdvalid1}, 0);
        chk("rst_data1", {24'd0, rddata1}, 0);
        chk("rst_busy", {30'd0, busy0, busy1}, 3);
        rst_n = 1'b1;
        bus_read = 1'b1;
        bus_addr = 17'h00000;
        step();
        chk("read_while_busy", {30'd0, rdvalid0, rdvalid1}, 0);
        bus_read = 1'b0;
        wait_idle("reset_clear_len", 1);

        do_read("clr_00000", 17'h00000, 8'hA5);
        do_read("clr_07fff", 17'h07FFF, 8'hA5);
        do_read("clr_18001", 17'h18001, 8'hA5);
        do_read("clr_1ffff", 17'h1FFFF, 8'hA5);

        // Byte lanes and block decode.
        do_write(17'h08000, 8'h11);
        do_write(17'h08001, 8'h22);
        do_write(17'h00000, 8'h33);
        do_read("lane_08000", 17'h08000, 8'h11);
        do_read("lane_08001", 17'h08001, 8'h22);
        do_read("lane_00000", 17'h00000, 8'h33);
        do_read("nbr_00001", 17'h00001, 8'hA5);
        do_read("nbr_18000", 17'h18000, 8'hA5);

        // Four back-to-back reads: REG_OUT=1 trails REG_OUT=0 by one cycle.
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                bus_addr = b2b_addr[i];
                bus_read = 1'b1;
            end else begin
                bus_read = 1'b0;
            end
            step();
            chk($sformatf("b2b_v0_%0d", i), {31'd0, rdvalid0}, (i < 4) ? 1 : 0);
            if (i < 4) chk($sformatf("b2b_d0_%0d", i), {24'd0, rddata0}, {24'd0, b2b_exp[i]});
            chk($sformatf("b2b_v1_%0d", i), {31'd0, rdvalid1}, (i >= 1) ? 1 : 0);
            if (i >= 1) chk($sformatf("b2b_d1_%0d", i), {24'd0, rddata1}, {24'd0, b2b_exp[i-1]});
        end
        bus_read = 1'b0;
        step();
        chk("b2b_tail", {30'd0, rdvalid0, rdvalid1}, 0);

        // Write and read together: write wins, no valid; next read sees new data.
        bus_addr   = 17'h00010;
        bus_wrdata = 8'h5A;
        bus_write  = 1'b1;
        bus_read   = 1'b1;
        step();
        bus_write  = 1'b0;
        chk("coll_v0", {31'd0, rdvalid0}, 0);
        step();
        bus_read = 1'b0;
        chk("coll_v1", {31'd0, rdvalid1}, 0);
        chk("coll_rd_v0", {31'd0, rdvalid0}, 1);
        chk("coll_rd_d0", {24'd0, rddata0}, 32'h5A);
        step();
        chk("coll_rd_v1", {31'd0, rdvalid1}, 1);
        chk("coll_rd_d1", {24'd0, rddata1}, 32'h5A);

        // Write immediately followed by a read of the same byte.
        do_write(17'h10003, 8'hC3);
        do_read("wr_then_rd", 17'h10003, 8'hC3);

        // clr_start right behind a read; the in-flight read still completes.
        bus_addr = 17'h00000;
        bus_read = 1'b1;
        step();
        bus_read  = 1'b0;
        clr_start = 1'b1;
        chk("inflight_v0", {31'd0, rdvalid0}, 1);
        chk("inflight_d0", {24'd0, rddata0}, 32'h33);
        chk("pre_clear_busy", {31'd0, busy0}, 0);
        step();
        clr_start = 1'b0;
        chk("inflight_v1", {31'd0, rdvalid1}, 1);
        chk("inflight_d1", {24'd0, rddata1}, 32'h33);
        chk("clear_busy", {30'd0, busy0, busy1}, 3);
        bus_addr   = 17'h00020;
        bus_wrdata = 8'h77;
        bus_write  = 1'b1;
        step();
        bus_write = 1'b0;
        bus_read  = 1'b1;
        step();
        bus_read = 1'b0;
        chk("busy_no_valid", {30'd0, rdvalid0, rdvalid1}, 0);
        wait_idle("req_clear_len", 2);
        do_read("post_clr_00020", 17'h00020, 8'hA5);
        do_read("post_clr_00000", 17'h00000, 8'hA5);

        // Reset in the middle of a requested clear restarts a full clear.
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (9000) step();
        chk("mid_busy", {31'd0, busy0}, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {30'd0, rdvalid0, rdvalid1}, 0);
        chk("mid_rst_busy", {30'd0, busy0, busy1}, 3);
        step();
        rst_n = 1'b1;
        wait_idle("restart_clear_len", 0);
        do_read("final_10003", 17'h10003, 8'hA5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
